// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED,
        TRAP
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BR   = 2'b01,
        PC_JAL  = 2'b10,
        PC_JALR = 2'b11
    } pc_src_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch_ctrl and imem.
interface fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_ctrl_next_pc.sv
// Next-PC target selection for sequential, branch, jal and jalr flow.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        target = pc + 32'd4;
        case (pc_src_t'(pc_src))
            PC_SEQ:  target = pc + 32'd4;
            PC_BR:   target = branch_taken ? (pc + imm) : (pc + 32'd4);
            PC_JAL:  target = pc + imm;
            PC_JALR: target = (rs1_val + imm) & ~32'd1;
            default: target = pc + 32'd4;
        endcase
        misaligned = is_misaligned(target);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC owner and fetch sequencer: fetches, holds the instruction for execution,
// and advances the PC on retire with halt and misaligned-target trap support.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    fetch_ctrl_if.master       imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               retire,
    input  logic               stall,
    input  logic [1:0]         pc_src,
    input  logic               branch_taken,
    input  logic [31:0]        imm,
    input  logic [31:0]        rs1_val,
    input  logic               halt_req,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               halted,
    output logic               trap,
    output logic [31:0]        trap_addr
);

    import fetch_pkg::*;

    fetch_state_t state, state_next;
    logic [31:0]  pc_r, pc_next;
    logic [31:0]  instr_r, instr_next;
    logic [31:0]  trap_addr_r, trap_addr_next;
    logic [31:0]  target;
    logic         misaligned;

    next_pc_calc u_next_pc (
        .pc           (pc_r),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .target       (target),
        .misaligned   (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pc_r        <= RESET_PC;
            instr_r     <= NOP_WORD;
            trap_addr_r <= '0;
        end else begin
            state       <= state_next;
            pc_r        <= pc_next;
            instr_r     <= instr_next;
            trap_addr_r <= trap_addr_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc_r;
        instr_next     = instr_r;
        trap_addr_next = trap_addr_r;
        case (state)
            IDLE: state_next = halt_req ? HALTED : FETCH;
            FETCH: begin
                if (imem.imem_ready) begin
                    instr_next = imem.imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (retire && !stall) begin
                    instr_next = NOP_WORD;
                    // A misaligned target keeps the faulting PC for inspection.
                    if (misaligned) begin
                        trap_addr_next = target;
                        state_next     = TRAP;
                    end else begin
                        pc_next    = target;
                        state_next = halt_req ? HALTED : FETCH;
                    end
                end
            end
            HALTED: begin
                if (!halt_req) state_next = FETCH;
            end
            TRAP:    state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc_r;
    assign instr          = instr_r;
    assign instr_valid    = (state == EXEC);
    assign pc             = pc_r;
    assign pc_plus4       = pc_r + 32'd4;
    assign halted         = (state == HALTED);
    assign trap           = (state == TRAP);
    assign trap_addr      = trap_addr_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; a second instance covers the RESET_PC wrap case.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ready, retire, stall, branch_taken, halt_req;
    logic [1:0]  pc_src;
    logic [31:0] rdata, imm, rs1_val;

    logic [31:0] instr, pc, pc_plus4, trap_addr;
    logic        instr_valid, halted, trap;
    logic [31:0] instr2, pc2, pc_plus42, trap_addr2;
    logic        instr_valid2, halted2, trap2;

    int checks = 0;
    int failures = 0;

    fetch_ctrl_if bus ();
    fetch_ctrl_if bus2 ();

    assign bus.imem_ready  = ready;
    assign bus.imem_rdata  = rdata;
    assign bus2.imem_ready = ready;
    assign bus2.imem_rdata = rdata;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .imem(bus),
        .instr(instr), .instr_valid(instr_valid),
        .retire(retire), .stall(stall), .pc_src(pc_src), .branch_taken(branch_taken),
        .imm(imm), .rs1_val(rs1_val), .halt_req(halt_req),
        .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .trap(trap), .trap_addr(trap_addr)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem(bus2),
        .instr(instr2), .instr_valid(instr_valid2),
        .retire(retire), .stall(stall), .pc_src(pc_src), .branch_taken(branch_taken),
        .imm(imm), .rs1_val(rs1_val), .halt_req(halt_req),
        .pc(pc2), .pc_plus4(pc_plus42), .halted(halted2), .trap(trap2), .trap_addr(trap_addr2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_op(input logic [1:0] src, input logic bt,
                             input logic [31:0] im, input logic [31:0] rs);
        pc_src = src; branch_taken = bt; imm = im; rs1_val = rs;
        retire = 1'b1;
        tick();
        retire = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ready = 1'b1; rdata = 32'h0050_0093;
        retire = 1'b0; stall = 1'b0; pc_src = 2'b00; branch_taken = 1'b0;
        imm = '0; rs1_val = '0; halt_req = 1'b0;
        tick(); tick();
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", bus.imem_req); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=00000000", pc); end
        checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL rst_pc_plus4 got=%h exp=00000004", pc_plus4); end
        checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", instr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0h exp=0", halted); end
        checks++; if (trap !== 1'b0) begin failures++; $display("FAIL rst_trap got=%0h exp=0", trap); end
        checks++; if (trap_addr !== 32'h0) begin failures++; $display("FAIL rst_trap_addr got=%h exp=00000000", trap_addr); end
        checks++; if (pc2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_pc_wrap got=%h exp=fffffffc", pc2); end
        rst = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rel_req got=%0h exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rel_addr got=%h exp=00000000", bus.imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rel_valid got=%0h exp=0", instr_valid); end
        checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rel_addr_wrap got=%h exp=fffffffc", bus2.imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr !== 32'h0050_0093) begin failures++; $display("FAIL first_instr got=%h exp=00500093", instr); end
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL exec_req got=%0h exp=0", bus.imem_req); end
    endtask

    task automatic test_sequential();
        retire_op(2'b00, 1'b0, '0, '0);
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL seq_req got=%0h exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h4) begin failures++; $display("FAIL seq_addr1 got=%h exp=00000004", bus.imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL seq_valid_drop got=%0h exp=0", instr_valid); end
        checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL seq_instr_nop got=%h exp=00000013", instr); end
        checks++; if (bus2.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=00000000", bus2.imem_addr); end
        tick();
        retire_op(2'b00, 1'b0, '0, '0);
        checks++; if (bus.imem_addr !== 32'h8) begin failures++; $display("FAIL seq_addr2 got=%h exp=00000008", bus.imem_addr); end
        tick();
        retire_op(2'b00, 1'b0, '0, '0);
        checks++; if (bus.imem_addr !== 32'hC) begin failures++; $display("FAIL seq_addr3 got=%h exp=0000000c", bus.imem_addr); end
        tick();
        stall = 1'b1; retire = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%0h exp=1", i, instr_valid); end
            checks++; if (pc !== 32'hC) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=0000000c", i, pc); end
            checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] got=%0h exp=0", i, bus.imem_req); end
        end
        stall = 1'b0; retire = 1'b0;
    endtask

    task automatic test_branch();
        retire_op(2'b00, 1'b0, '0, '0);
        checks++; if (bus.imem_addr !== 32'h10) begin failures++; $display("FAIL br_setup got=%h exp=00000010", bus.imem_addr); end
        tick();
        retire_op(2'b01, 1'b1, 32'hFFFF_FFF8, '0);
        checks++; if (bus.imem_addr !== 32'h08) begin failures++; $display("FAIL br_taken got=%h exp=00000008", bus.imem_addr); end
        tick();
        retire_op(2'b10, 1'b0, 32'h8, '0);
        checks++; if (bus.imem_addr !== 32'h10) begin failures++; $display("FAIL jal_fwd got=%h exp=00000010", bus.imem_addr); end
        tick();
        retire_op(2'b01, 1'b0, 32'hFFFF_FFF8, '0);
        checks++; if (bus.imem_addr !== 32'h14) begin failures++; $display("FAIL br_not_taken got=%h exp=00000014", bus.imem_addr); end
        tick();
        retire_op(2'b10, 1'b0, 32'hFFFF_FFFC, '0);
        checks++; if (bus.imem_addr !== 32'h10) begin failures++; $display("FAIL jal_back got=%h exp=00000010", bus.imem_addr); end
        tick();
        retire_op(2'b10, 1'b0, 32'h100, '0);
        checks++; if (bus.imem_addr !== 32'h110) begin failures++; $display("FAIL jal_0x100 got=%h exp=00000110", bus.imem_addr); end
        tick();
        checks++; if (pc_plus4 !== 32'h114) begin failures++; $display("FAIL link_val got=%h exp=00000114", pc_plus4); end
    endtask

    task automatic test_jalr();
        retire_op(2'b11, 1'b0, 32'h4, 32'h2001);
        checks++; if (bus.imem_addr !== 32'h2004) begin failures++; $display("FAIL jalr_lsb got=%h exp=00002004", bus.imem_addr); end
        checks++; if (trap !== 1'b0) begin failures++; $display("FAIL jalr_no_trap got=%0h exp=0", trap); end
        tick();
    endtask

    task automatic test_wait_states();
        ready = 1'b0;
        retire_op(2'b00, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.imem_addr !== 32'h2008) begin failures++; $display("FAIL wait_addr[%0d] got=%h exp=00002008", i, bus.imem_addr); end
            checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL wait_req[%0d] got=%0h exp=1", i, bus.imem_req); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL wait_valid[%0d] got=%0h exp=0", i, instr_valid); end
            tick();
        end
        rdata = 32'h1234_5678; ready = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL wait_done_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr !== 32'h1234_5678) begin failures++; $display("FAIL wait_done_instr got=%h exp=12345678", instr); end
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        retire_op(2'b00, 1'b0, '0, '0);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_set got=%0h exp=1", halted); end
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL halt_req_low got=%0h exp=0", bus.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%0h exp=0", instr_valid); end
        checks++; if (pc !== 32'h200C) begin failures++; $display("FAIL halt_pc got=%h exp=0000200c", pc); end
        tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_hold got=%0h exp=1", halted); end
        halt_req = 1'b0;
        tick();
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear got=%0h exp=0", halted); end
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL resume_req got=%0h exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h200C) begin failures++; $display("FAIL resume_addr got=%h exp=0000200c", bus.imem_addr); end
        tick();
    endtask

    task automatic test_trap();
        retire_op(2'b11, 1'b0, 32'h0, 32'h2002);
        checks++; if (trap !== 1'b1) begin failures++; $display("FAIL trap_set got=%0h exp=1", trap); end
        checks++; if (trap_addr !== 32'h2002) begin failures++; $display("FAIL trap_addr got=%h exp=00002002", trap_addr); end
        checks++; if (pc !== 32'h200C) begin failures++; $display("FAIL trap_pc got=%h exp=0000200c", pc); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL trap_valid got=%0h exp=0", instr_valid); end
        checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL trap_instr got=%h exp=00000013", instr); end
        retire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL trap_no_req[%0d] got=%0h exp=0", i, bus.imem_req); end
            checks++; if (trap !== 1'b1) begin failures++; $display("FAIL trap_sticky[%0d] got=%0h exp=1", i, trap); end
        end
        retire = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        rst = 1'b0;
        tick();
        checks++; if (trap !== 1'b0) begin failures++; $display("FAIL trap_cleared got=%0h exp=0", trap); end
        rst = 1'b1; ready = 1'b1;
        tick(); tick();
        ready = 1'b0;
        retire_op(2'b10, 1'b0, 32'h40, '0);
        checks++; if (bus.imem_addr !== 32'h40) begin failures++; $display("FAIL midf_addr got=%h exp=00000040", bus.imem_addr); end
        rst = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL midf_req got=%0h exp=0", bus.imem_req); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL midf_pc got=%h exp=00000000", pc); end
        rst = 1'b1; halt_req = 1'b1;
        tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL idle_halt got=%0h exp=1", halted); end
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL idle_halt_req got=%0h exp=0", bus.imem_req); end
        halt_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_wait_states();
        test_halt();
        test_trap();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
